// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with fill level, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN at compile time for first-word-fall-through read mode.
module sync_fifo #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 8,
  parameter int AF_THRESH = (1 << ADDR_SIZE) - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] w_data,
  input  logic                 w_en,
  input  logic                 r_en,
  input  logic                 clr_err,
  output logic [DATA_SIZE-1:0] r_data,
  output logic                 w_full,
  output logic                 r_empty,
  output logic                 w_almost_full,
  output logic                 r_almost_empty,
  output logic [ADDR_SIZE:0]   fill_level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] FULL_LVL = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AF_LVL   = (ADDR_SIZE+1)'(AF_THRESH);
  localparam logic [ADDR_SIZE:0] AE_LVL   = (ADDR_SIZE+1)'(AE_THRESH);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE:0]   wptr, rptr, fill_nxt;
  logic                 w_acc, r_acc, rd_adv, empty_nxt;

  // Writes are masked during reset so the array is never touched while rst_n is low.
  assign w_acc = w_en & ~w_full & rst_n;
  assign r_acc = r_en & ~r_empty;

  always_comb begin
    fill_nxt = fill_level + {{ADDR_SIZE{1'b0}}, w_acc} - {{ADDR_SIZE{1'b0}}, r_acc};
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Words still in the array; the output register holds one more when r_empty is low.
  logic [ADDR_SIZE:0] mem_cnt;
  assign mem_cnt   = wptr - rptr;
  assign rd_adv    = (r_empty | r_acc) & (mem_cnt != '0);
  assign empty_nxt = ~rd_adv & (r_empty | r_acc);
`else
  assign rd_adv    = r_acc;
  assign empty_nxt = (fill_nxt == '0);
`endif

  always_ff @(posedge clk) begin
    if (w_acc) mem[wptr[ADDR_SIZE-1:0]] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr           <= '0;
      rptr           <= '0;
      fill_level     <= '0;
      r_data         <= '0;
      r_empty        <= 1'b1;
      w_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      w_almost_full  <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      if (w_acc) wptr <= wptr + 1'b1;
      if (rd_adv) begin
        rptr   <= rptr + 1'b1;
        r_data <= mem[rptr[ADDR_SIZE-1:0]];
      end
      fill_level     <= fill_nxt;
      r_empty        <= empty_nxt;
      w_full         <= (fill_nxt == FULL_LVL);
      w_almost_full  <= (fill_nxt >= AF_LVL);
      r_almost_empty <= (fill_nxt <= AE_LVL);
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow       <= (w_en & w_full)  | (overflow  & ~clr_err);
      underflow      <= (r_en & r_empty) | (underflow & ~clr_err);
    end
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: the successor to the 256 x 32 FIFO in the RGB-to-RGBW pixel path, for designs where producer and consumer share one clock. It adds a fill-level output, threshold-programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. An optional first-word-fall-through read mode is selected at compile time. It sits between the pixel input stage and the RGBW conversion pipeline, buffering pixel words.

## Interface
- DATA_SIZE, 32, width of one stored word in bits
- ADDR_SIZE, 8, log2 of depth; DEPTH = 2^ADDR_SIZE words
- AF_THRESH, 2^ADDR_SIZE-4, w_almost_full asserts when fill_level >= AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 4, r_almost_empty asserts when fill_level <= AE_THRESH; legal range 0..DEPTH-1
- clk  input  1  single clock for all logic, rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- w_data  input  DATA_SIZE  write word
- w_en  input  1  write request
- r_en  input  1  read request (acknowledge in FWFT mode)
- clr_err  input  1  clears overflow and underflow
- r_data  output  DATA_SIZE  read word
- w_full  output  1  fill_level == DEPTH
- r_empty  output  1  no readable word
- w_almost_full  output  1  threshold flag
- r_almost_empty  output  1  threshold flag
- fill_level  output  ADDR_SIZE+1  words accepted and not yet read, 0..DEPTH
- overflow  output  1  sticky: a write was attempted while full
- underflow  output  1  sticky: a read was attempted while empty

## Operation
- Storage: DEPTH x DATA_SIZE array. Write and read pointers are ADDR_SIZE+1-bit binary and wrap modulo 2*DEPTH. The array is addressed by the low ADDR_SIZE bits.
- Write accepted = w_en & ~w_full. Read accepted = r_en & ~r_empty. Rejected requests leave the pointers, the array and fill_level unchanged.
- fill_level: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither are accepted.
- Simultaneous w_en and r_en:
  - When full, the read is accepted and the write is rejected; overflow sets.
  - When empty, the write is accepted and the read is rejected; underflow sets.
  - Otherwise both are accepted and fill_level holds.
- Error flags:
  - overflow sets on w_en & w_full; underflow sets on r_en & r_empty.
  - Both clear on clr_err. A set condition in the same cycle as clr_err wins.
- All flags are registered and derived from the next-state fill_level, so they change in the same cycle as fill_level.
- Reset (rst_n low at a rising edge), including mid-operation:
  - Pointers and fill_level go to 0; r_data goes to 0.
  - r_empty=1, w_full=0, r_almost_empty=1, w_almost_full=0, overflow=0, underflow=0.
  - Array contents are not cleared.
  - w_en and r_en are ignored during reset.

## Timing
- Standard mode:
  - An accepted write at edge N is reflected in fill_level, r_empty and the other flags after edge N.
  - An accepted read at edge N places the word on r_data after edge N (1-cycle latency).
  - r_data holds its last value until the next accepted read.
- Back-to-back writes or reads on every cycle are sustained at full throughput.
- w_full deasserts the cycle after a read is accepted from a full FIFO; a write may then be accepted on that next edge.
- Wrap-around: pointers cross 2^(ADDR_SIZE+1)-1 -> 0 with no throughput loss. Full and empty are distinguished by fill_level, not by pointer equality alone.

## Configuration
- SYNC_FIFO_FWFT_EN undefined: standard mode as described above.
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - r_data presents the head word whenever r_empty=0.
  - r_en acknowledges the head; the next word, if any, appears on r_data after the same edge.
  - The first write into an empty FIFO drops r_empty 2 cycles after the write edge (write, then prefetch into the output register).
  - Capacity stays DEPTH, and fill_level counts every unread word including the one held in the output register.
  - With r_empty=1, r_data holds its last value.

## Test plan
- Reset, then write 0,1,2,3 on consecutive cycles, then assert r_en for 6 cycles:
  - Read returns 0,1,2,3; fill_level goes 4 -> 0; r_empty=1 after the 4th read.
  - underflow=1 after the 5th r_en; the pointers do not move.
- Write 0..DEPTH+1 (258 words):
  - w_full=1 at fill_level=256; w_almost_full=1 from fill_level=252.
  - overflow=1; words 256 and 257 are dropped.
  - Reading 258 times returns 0..255 in order.
- With fill_level=128, drive w_en and r_en together for 50 cycles:
  - fill_level stays 128 and the data order is preserved.
- Fill the FIFO, then drive w_en and r_en together for one cycle:
  - Read accepted, write rejected, fill_level=255, overflow=1.
  - Assert clr_err: overflow returns to 0.
- Assert rst_n=0 for one cycle mid-burst at fill_level=37:
  - All outputs take their reset values on the next cycle.
  - A subsequent write/read of 0xA5A5A5A5 returns that value.
- With SYNC_FIFO_FWFT_EN defined, write 0xDEADBEEF into an empty FIFO:
  - r_empty=0 and r_data=0xDEADBEEF two cycles later, with no r_en asserted.
  - A single r_en returns r_empty to 1.
